// File: rtl/pipe_cond_pkg.sv
// Shared types and constants for the execute-stage condition/flag unit.
// Used by pipe_cond_check and pipe_cond_unit.
package pipe_cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/pipe_cond_check.sv
// Combinational condition evaluator: maps a condition field and the
// architectural {N,Z,C,V} flags to a pass/fail execute decision.
import pipe_cond_pkg::*;

module pipe_cond_check (
    input  cond_t      cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // NV is architecturally "never": the instruction is squashed unconditionally.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = ~z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_cond_unit.sv
// Execute-stage flag register, condition gating of PCSrc/RegWrite/MemWrite.
// Define PIPE_COND_STATS_EN to add saturating ExecCnt/SquashCnt outputs.
import pipe_cond_pkg::*;

module pipe_cond_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWE,
    input  logic [3:0]       ALUFlags,
    input  logic             PCSE,
    input  logic             RegWE,
    input  logic             MemWE,
    input  logic             NoWriteE,
    input  logic             FlagLoad,
    input  logic [3:0]       FlagLoadData,
    output logic [3:0]       Flags,
    output logic             CondExE,
    output logic             PCSrcE,
    output logic             RegWriteE,
    output logic             MemWriteE
`ifdef PIPE_COND_STATS_EN
    ,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
`endif
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic       advance;
    logic       commit;
    cond_t      cond_e;

    assign cond_e = cond_t'(CondE);

    pipe_cond_check u_check (
        .cond    (cond_e),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign advance   = ValidE & ~StallE;
    assign commit    = advance & cond_ex;

    assign Flags     = flags_q;
    assign CondExE   = cond_ex & ValidE;
    assign PCSrcE    = PCSE & CondExE;
    assign MemWriteE = MemWE & CondExE;
    assign RegWriteE = RegWE & CondExE & ~NoWriteE;

    // A direct flag load overrides any ALU commit in the same cycle.
    always_comb begin
        flags_d = flags_q;
        if (FlagLoad) begin
            flags_d = FlagLoadData;
        end else if (commit) begin
            if (FlagWE[FLAGW_NZ]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagWE[FLAGW_CV]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef PIPE_COND_STATS_EN
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    // Each non-stalled valid slot is counted exactly once, saturating at all-ones.
    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (advance) begin
            if (cond_ex) begin
                if (exec_cnt_q != '1) begin
                    exec_cnt_d = exec_cnt_q + CNT_W'(1);
                end
            end else begin
                if (squash_cnt_q != '1) begin
                    squash_cnt_d = squash_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign ExecCnt   = exec_cnt_q;
    assign SquashCnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_cond_unit.sv
// Self-checking bench for pipe_cond_unit: directed scenarios followed by random
// traffic compared against a table-driven flag/condition reference model.
module tb_pipe_cond_unit;

    localparam int CntW = 4;

    logic            clk;
    logic            reset;
    logic            ValidE;
    logic            StallE;
    logic [3:0]      CondE;
    logic [1:0]      FlagWE;
    logic [3:0]      ALUFlags;
    logic            PCSE;
    logic            RegWE;
    logic            MemWE;
    logic            NoWriteE;
    logic            FlagLoad;
    logic [3:0]      FlagLoadData;
    logic [3:0]      Flags;
    logic            CondExE;
    logic            PCSrcE;
    logic            RegWriteE;
    logic            MemWriteE;
`ifdef PIPE_COND_STATS_EN
    logic [CntW-1:0] ExecCnt;
    logic [CntW-1:0] SquashCnt;
`endif

    int         checks;
    int         failures;
    logic [3:0] modelFlags;
    int         modelExec;
    int         modelSquash;

    pipe_cond_unit #(.CNT_W(CntW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ValidE       (ValidE),
        .StallE       (StallE),
        .CondE        (CondE),
        .FlagWE       (FlagWE),
        .ALUFlags     (ALUFlags),
        .PCSE         (PCSE),
        .RegWE        (RegWE),
        .MemWE        (MemWE),
        .NoWriteE     (NoWriteE),
        .FlagLoad     (FlagLoad),
        .FlagLoadData (FlagLoadData),
        .Flags        (Flags),
        .CondExE      (CondExE),
        .PCSrcE       (PCSrcE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE)
`ifdef PIPE_COND_STATS_EN
        ,
        .ExecCnt      (ExecCnt),
        .SquashCnt    (SquashCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conditions come in true/false pairs: odd codes invert the even code's test.
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c >> 1)
            0:       base = z;
            1:       base = cf;
            2:       base = n;
            3:       base = v;
            4:       base = cf && !z;
            5:       base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h @%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [3:0] c,
                                 input logic [1:0] fw, input logic [3:0] alu,
                                 input logic pcs, input logic rw, input logic mw,
                                 input logic nw, input logic fl, input logic [3:0] fd);
        ValidE       = v;
        StallE       = s;
        CondE        = c;
        FlagWE       = fw;
        ALUFlags     = alu;
        PCSE         = pcs;
        RegWE        = rw;
        MemWE        = mw;
        NoWriteE     = nw;
        FlagLoad     = fl;
        FlagLoadData = fd;
    endtask

    // Called just after a negedge with inputs applied; returns just after the next negedge.
    task automatic runCycle(input string tag);
        logic pass;
        #1;
        pass = ValidE && refCond(CondE, modelFlags);
        checkOutput({tag, "_condex"}, CondExE, pass);
        checkOutput({tag, "_pcsrc"}, PCSrcE, PCSE && pass);
        checkOutput({tag, "_memw"}, MemWriteE, MemWE && pass);
        checkOutput({tag, "_regw"}, RegWriteE, RegWE && pass && !NoWriteE);
        @(posedge clk);
        if (FlagLoad) begin
            modelFlags = FlagLoadData;
        end else if (pass && !StallE) begin
            if (FlagWE[1]) modelFlags[3:2] = ALUFlags[3:2];
            if (FlagWE[0]) modelFlags[1:0] = ALUFlags[1:0];
        end
        if (ValidE && !StallE) begin
            if (pass) modelExec = (modelExec < 15) ? modelExec + 1 : 15;
            else      modelSquash = (modelSquash < 15) ? modelSquash + 1 : 15;
        end
        #1;
        checkOutput({tag, "_flags"}, Flags, modelFlags);
`ifdef PIPE_COND_STATS_EN
        checkOutput({tag, "_exec"}, ExecCnt, modelExec);
        checkOutput({tag, "_squash"}, SquashCnt, modelSquash);
`endif
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        modelFlags  = 4'h0;
        modelExec   = 0;
        modelSquash = 0;
        reset       = 1'b0;
        applyStimulus(0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0, 4'h0);

        // Preload all flags, then assert reset between clock edges.
        @(negedge clk);
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        applyStimulus(0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 1, 4'hF);
        runCycle("preload");
        applyStimulus(0, 0, 4'hE, 2'b00, 4'h0, 1, 1, 1, 0, 0, 4'h0);
        #2 reset = 1'b1;
        modelFlags  = 4'h0;
        modelExec   = 0;
        modelSquash = 0;
        #1;
        checkOutput("t1_async_flags", Flags, 4'h0);
        checkOutput("t1_bubble_pcsrc", PCSrcE, 1'b0);
        checkOutput("t1_bubble_regw", RegWriteE, 1'b0);
        checkOutput("t1_bubble_memw", MemWriteE, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed scenarios");
        applyStimulus(0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 1, 4'b0100);
        runCycle("t2_load");
        applyStimulus(1, 0, 4'h0, 2'b00, 4'h0, 1, 0, 0, 0, 0, 4'h0);
        #1 checkOutput("t2_eq_pcsrc", PCSrcE, 1'b1);
        runCycle("t2_eq");
        applyStimulus(1, 0, 4'h1, 2'b00, 4'h0, 1, 0, 0, 0, 0, 4'h0);
        #1 checkOutput("t2_ne_pcsrc", PCSrcE, 1'b0);
        runCycle("t2_ne");

        applyStimulus(1, 0, 4'hE, 2'b11, 4'b1001, 0, 1, 0, 1, 0, 4'h0);
        #1 checkOutput("t3_cmp_regw", RegWriteE, 1'b0);
        runCycle("t3_cmp");
        checkOutput("t3_cmp_flags", Flags, 4'b1001);

        applyStimulus(0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 1, 4'b1011);
        runCycle("t4_load");
        applyStimulus(1, 0, 4'hE, 2'b10, 4'b0111, 0, 1, 0, 0, 0, 4'h0);
        runCycle("t4_nz");
        checkOutput("t4_nz_flags", Flags, 4'b0111);
        applyStimulus(1, 0, 4'hF, 2'b11, 4'b0000, 1, 1, 1, 0, 0, 4'h0);
        runCycle("t4_nv");
        checkOutput("t4_nv_flags", Flags, 4'b0111);

        applyStimulus(1, 1, 4'hE, 2'b11, 4'b1111, 1, 1, 1, 0, 0, 4'h0);
        runCycle("t5_stall");
        checkOutput("t5_stall_flags", Flags, 4'b0111);
        applyStimulus(1, 1, 4'hE, 2'b11, 4'b1111, 0, 0, 0, 0, 1, 4'b0010);
        runCycle("t5_load");
        checkOutput("t5_load_flags", Flags, 4'b0010);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
                          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                          4'($urandom_range(0, 15)));
            runCycle("rand");
        end

        // Reset held across an edge that would otherwise commit flags.
        applyStimulus(1, 0, 4'hE, 2'b11, 4'hF, 0, 0, 0, 0, 0, 4'h0);
        #2 reset = 1'b1;
        modelFlags  = 4'h0;
        modelExec   = 0;
        modelSquash = 0;
        @(posedge clk);
        #1 checkOutput("midreset_flags", Flags, 4'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 4'hE, 2'b00, 4'h0, 0, 1, 0, 0, 0, 4'h0);
            runCycle("t6_exec");
        end
`ifdef PIPE_COND_STATS_EN
        checkOutput("t6_exec_sat", ExecCnt, 4'hF);
        checkOutput("t6_squash_zero", SquashCnt, 4'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
